// File: rtl/mem_line_burst_ctrl.sv
// mem_line_burst_ctrl: line refill/writeback burst sequencer with emulated memory latency; MEM_BURST_STATS_EN adds op counters
module mem_line_burst_ctrl #(
  parameter int ADDR_LEN = 11,
  parameter int LINE_ADDR_LEN = 3,
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_rd,
  input  logic req_wr,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] req_line,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0] wr_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0] rd_line,
  output logic done,
  output logic busy,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic mem_wr_req,
  output logic [31:0] mem_wr_data,
`ifdef MEM_BURST_STATS_EN
  input  logic [31:0] mem_rd_data,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`else
  input  logic [31:0] mem_rd_data
`endif
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int LW = ADDR_LEN - LINE_ADDR_LEN;
  typedef enum logic [2:0] {IDLE, WAIT, WRITE, READ, READ_TAIL, DONE} state_t;
  state_t state, state_n;
  logic [31:0] cnt;
  logic [LINE_ADDR_LEN-1:0] idx, widx;
  logic [LW-1:0] line;
  logic [32*LINE_SIZE-1:0] data;
  logic op_wr, cap;
  assign idx = cnt[LINE_ADDR_LEN-1:0];
  // next state and memory-port drive, all derived from the current state
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = state == DONE;
    mem_wr_req = state == WRITE;
    mem_addr = (state == WRITE || state == READ) ? {line, idx} : '0;
    mem_wr_data = mem_wr_req ? data[32*idx +: 32] : '0;
    widx = idx - 1'b1;
    cap = (state == READ && idx != '0) || state == READ_TAIL;
    case (state)
      IDLE: if (req_wr || req_rd) state_n = LATENCY == 0 ? (req_wr ? WRITE : READ) : WAIT;
      WAIT: if (cnt == LATENCY - 1) state_n = op_wr ? WRITE : READ;
      WRITE: if (&idx) state_n = DONE;
      READ: if (&idx) state_n = READ_TAIL;
      READ_TAIL: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // state, counter, accepted request and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      data <= '0;
      op_wr <= 1'b0;
      rd_line <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == state_n && state inside {WAIT, WRITE, READ}) ? cnt + 1 : '0;
      if (state == IDLE && (req_wr || req_rd)) begin
        line <= req_line;
        data <= wr_line;
        op_wr <= req_wr;
      end
      if (cap) rd_line[32*widx +: 32] <= mem_rd_data;
    end
  end
`ifdef MEM_BURST_STATS_EN
  // completed-op counters, bumped in the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == DONE) begin
      if (op_wr) wr_cnt <= wr_cnt + 1;
      else rd_cnt <= rd_cnt + 1;
    end
  end
`endif
endmodule
